// File: rtl/mlp_layer_ctrl.sv
// Sequencer for one fully-connected MLP layer around a combinational dot-product unit.
// Optional ReLU on each neuron result is enabled by defining MLP_CTRL_RELU_EN.
module mlp_layer_ctrl #(
    parameter int DATA_W  = 32,
    parameter int IN_DIM  = 4,
    parameter int OUT_DIM = 4,
    localparam int AW     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IN_DIM*DATA_W-1:0] in_vec,
    output logic                     busy,
    output logic                     done,
    output logic                     w_rd_en,
    output logic [AW-1:0]            w_addr,
    input  logic [IN_DIM*DATA_W-1:0] w_rd_data,
    input  logic [DATA_W-1:0]        b_rd_data,
    output logic [IN_DIM*DATA_W-1:0] dp_vec_a,
    output logic [IN_DIM*DATA_W-1:0] dp_vec_b,
    input  logic [DATA_W-1:0]        dp_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [AW-1:0]            out_idx,
    output logic [DATA_W-1:0]        out_data
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [AW-1:0]            n_q, n_d;
    logic [IN_DIM*DATA_W-1:0] vec_q, vec_d;
    logic [IN_DIM*DATA_W-1:0] wgt_q, wgt_d;
    logic [DATA_W-1:0]        bias_q, bias_d;
    logic [DATA_W-1:0]        res_q, res_d;
    logic [DATA_W-1:0]        sum, act;

    // Bias add wraps at DATA_W bits; ReLU only clamps the wrapped value.
    always_comb begin
        sum = dp_out + bias_q;
`ifdef MLP_CTRL_RELU_EN
        act = sum[DATA_W-1] ? '0 : sum;
`else
        act = sum;
`endif
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        vec_d   = vec_q;
        wgt_d   = wgt_q;
        bias_d  = bias_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d   = in_vec;
                    n_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                wgt_d   = w_rd_data;
                bias_d  = b_rd_data;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                res_d   = act;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // Holding here on backpressure keeps the memory idle and outputs stable.
                if (out_ready) begin
                    if (n_q == AW'(OUT_DIM - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            vec_q   <= '0;
            wgt_q   <= '0;
            bias_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            vec_q   <= vec_d;
            wgt_q   <= wgt_d;
            bias_q  <= bias_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign w_rd_en   = (state_q == S_FETCH);
    assign w_addr    = n_q;
    assign dp_vec_a  = vec_q;
    assign dp_vec_b  = wgt_q;
    assign out_valid = (state_q == S_WRITE);
    assign out_idx   = n_q;
    assign out_data  = res_q;

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// Scoreboard bench for mlp_layer_ctrl: a 16-bit 4x3 layer plus an 8-bit 1x1 wrap instance.
module tb_mlp_layer_ctrl;
    localparam int DW = 16, ID = 4, OD = 3, AW = 2;

`ifdef MLP_CTRL_RELU_EN
    localparam int EXP_N1 = 0;
    localparam int EXP_WRAP = 0;
`else
    localparam int EXP_N1 = -6;
    localparam int EXP_WRAP = -56;
`endif

    typedef struct {int idx; int data;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic              start, busy, done, w_rd_en, out_valid, out_ready;
    logic [ID*DW-1:0]  in_vec, w_rd_data, dp_vec_a, dp_vec_b;
    logic [DW-1:0]     b_rd_data, dp_out, out_data;
    logic [AW-1:0]     w_addr, out_idx;

    // wrap instance
    logic              start_w, busy_w, done_w, w_rd_en_w, out_valid_w;
    logic [7:0]        in_w, w_rd_data_w, b_rd_data_w, dp_a_w, dp_b_w, dp_out_w, out_data_w;
    logic [0:0]        w_addr_w, out_idx_w;

    mlp_layer_ctrl #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD)) dut (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data), .b_rd_data(b_rd_data),
        .dp_vec_a(dp_vec_a), .dp_vec_b(dp_vec_b), .dp_out(dp_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data));

    mlp_layer_ctrl #(.DATA_W(8), .IN_DIM(1), .OUT_DIM(1)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .in_vec(in_w), .busy(busy_w), .done(done_w),
        .w_rd_en(w_rd_en_w), .w_addr(w_addr_w), .w_rd_data(w_rd_data_w), .b_rd_data(b_rd_data_w),
        .dp_vec_a(dp_a_w), .dp_vec_b(dp_b_w), .dp_out(dp_out_w), .out_valid(out_valid_w),
        .out_ready(1'b1), .out_idx(out_idx_w), .out_data(out_data_w));

    // dot-product models
    always_comb begin
        int acc;
        acc = 0;
        for (int i = 0; i < ID; i++)
            acc += int'($signed(dp_vec_a[i*DW +: DW])) * int'($signed(dp_vec_b[i*DW +: DW]));
        dp_out = acc[DW-1:0];
    end
    always_comb begin
        int p;
        p = int'($signed(dp_a_w)) * int'($signed(dp_b_w));
        dp_out_w = p[7:0];
    end

    // weight memories, one-cycle read latency
    logic [ID*DW-1:0] wrow [OD];
    logic [DW-1:0]    brow [OD];
    initial begin
        wrow[0] = {16'sd1, 16'sd1, 16'sd1, 16'sd1};
        wrow[1] = {16'sd0, 16'sd0, 16'sd0, -16'sd1};
        wrow[2] = {16'sd2, 16'sd2, 16'sd2, 16'sd2};
        brow[0] = 16'sd0;
        brow[1] = -16'sd5;
        brow[2] = 16'sd1;
    end
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_rd_data <= wrow[w_addr];
            b_rd_data <= brow[w_addr];
        end
        if (w_rd_en_w) begin
            w_rd_data_w <= 8'd2;
            b_rd_data_w <= 8'd0;
        end
    end

    int total = 0, bad = 0;
    int cyc = 0, s_cyc = 0, s_w = 0;
    int done_cnt = 0, done_at = -1, rd_cnt = 0, busy_cnt = 0;
    int done_w_at = -1;
    exp_t q[$], qw[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc - s_cyc);
        end
    endtask

    // monitors: compare the front of the queue every cycle out_valid is high, pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin done_cnt++; done_at = cyc - s_cyc; end
            if (busy) busy_cnt++;
            if (w_rd_en) rd_cnt++;
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    chk("out_idx", int'(out_idx), q[0].idx);
                    chk("out_data", int'($signed(out_data)), q[0].data);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (done_w) done_w_at = cyc - s_w;
            if (out_valid_w) begin
                if (qw.size() == 0) chk("unexpected_out_w", 1, 0);
                else begin
                    chk("wrap_out_data", int'($signed(out_data_w)), qw[0].data);
                    void'(qw.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_pass(input logic [ID*DW-1:0] v);
        start = 1'b1;
        in_vec = v;
        s_cyc = cyc;
        done_cnt = 0; done_at = -1; rd_cnt = 0; busy_cnt = 0;
        q.push_back('{0, 10});
        q.push_back('{1, EXP_N1});
        q.push_back('{2, 21});
        tick;
        start = 1'b0;
    endtask

    task automatic finish_pass(input int want_done);
        int k;
        k = 0;
        while (done_at < 0 && k < 80) begin tick; k++; end
        chk("done_cycle", done_at, want_done);
        tick; tick;
        chk("done_count", done_cnt, 1);
        chk("busy_after_pass", int'(busy), 0);
        chk("queue_drained", q.size(), 0);
    endtask

    localparam logic [ID*DW-1:0] V  = {16'sd4, 16'sd3, 16'sd2, 16'sd1};
    localparam logic [ID*DW-1:0] V2 = {16'sd9, 16'sd9, 16'sd9, 16'sd9};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; in_vec = '0; out_ready = 1; start_w = 0; in_w = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_w_rd_en", int'(w_rd_en), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_dp_vec_b", int'(dp_vec_b != '0), 0);
        rst = 0;
        tick;

        // basic pass
        begin_pass(V);
        finish_pass(13);
        chk("busy_cycles", busy_cnt, 13);
        chk("rd_pulses", rd_cnt, 3);

        // backpressure in the first WRITE for cycles 4..6
        begin_pass(V);
        while (cyc - s_cyc < 4) tick;
        out_ready = 0;
        while (cyc - s_cyc < 7) tick;
        out_ready = 1;
        finish_pass(16);
        chk("rd_pulses_bp", rd_cnt, 3);

        // start pulses while busy are ignored
        begin_pass(V);
        while (cyc - s_cyc < 2) tick;
        start = 1; in_vec = V2;
        tick;
        start = 0;
        while (cyc - s_cyc < 7) tick;
        start = 1;
        tick;
        start = 0;
        finish_pass(13);
        repeat (10) tick;
        chk("done_count_late", done_cnt, 1);
        chk("busy_late", int'(busy), 0);

        // reset during the second WAIT (cycle 6)
        begin_pass(V);
        while (cyc - s_cyc < 6) tick;
        rst = 1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_w_addr", int'(w_addr), 0);
        chk("midrst_out_idx", int'(out_idx), 0);
        chk("midrst_dp_vec_a", int'(dp_vec_a != '0), 0);
        chk("midrst_partial", q.size(), 2);
        tick;
        rst = 0;
        q.delete();
        repeat (12) tick;
        chk("midrst_no_done", done_cnt, 0);
        begin_pass(V);
        finish_pass(13);

        // 8-bit wrap instance
        start_w = 1; in_w = 8'd100; s_w = cyc; done_w_at = -1;
        qw.push_back('{0, EXP_WRAP});
        tick;
        start_w = 0;
        for (int k = 0; k < 20 && done_w_at < 0; k++) tick;
        chk("wrap_done_cycle", done_w_at, 5);
        tick;
        chk("wrap_queue_drained", qw.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mlp_layer_ctrl.md
# mlp_layer_ctrl

Sequencer for one fully-connected MLP layer built around the combinational `dotprod` datapath. It latches one input activation vector on `start`. For each output neuron it then fetches a weight row and bias from a synchronous weight memory, drives the dot-product unit, and adds the bias. It applies optional ReLU and emits one result per neuron on a valid/ready stream. It sits between the layer weight store and the next layer's input buffer.

## Interface
- `DATA_W`, default 32: signed word width of activations, weights, bias and results.
- `IN_DIM`, default 4: input vector length, ≥1.
- `OUT_DIM`, default 4: number of output neurons, ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a layer pass; sampled only in IDLE.
- `in_vec`  in  IN_DIM*DATA_W  input activations, packed; element i is at bits [i*DATA_W +: DATA_W]. Latched on the accepted start.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result handshake.
- `w_rd_en`  out  1  weight/bias read strobe.
- `w_addr`  out  $clog2(OUT_DIM) (min 1)  neuron index being read.
- `w_rd_data`  in  IN_DIM*DATA_W  weight row; valid exactly one cycle after `w_rd_en`.
- `b_rd_data`  in  DATA_W  bias; same timing as `w_rd_data`.
- `dp_vec_a`  out  IN_DIM*DATA_W  to `dotprod` vec_A; carries the latched input vector.
- `dp_vec_b`  out  IN_DIM*DATA_W  to `dotprod` vec_B; carries the registered weight row.
- `dp_out`  in  DATA_W  combinational dot product returned by `dotprod`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_idx`  out  $clog2(OUT_DIM) (min 1)  neuron index of `out_data`.
- `out_data`  out  DATA_W  signed neuron result.

## Operation
- States: IDLE, FETCH, WAIT, COMPUTE, WRITE, DONE. Reset state is IDLE.
- **IDLE:** when `start`=1, latch `in_vec`, clear neuron index `n`, and go to FETCH. Otherwise stay in IDLE.
- **FETCH:** assert `w_rd_en`=1 with `w_addr`=n for exactly one cycle, then go to WAIT.
- **WAIT:** capture `w_rd_data` into the weight register and `b_rd_data` into the bias register, then go to COMPUTE.
- **COMPUTE:** `dp_vec_b` holds the weight register. Register `result = dp_out + bias`, truncated to DATA_W (two's-complement wrap, no saturation), then go to WRITE.
- **WRITE:** `out_valid`=1 and `out_idx`=n. `out_data` and `out_idx` stay stable until `out_valid && out_ready`.
  - On that handshake, if n==OUT_DIM-1, go to DONE.
  - Otherwise increment n and go to FETCH.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in every state other than IDLE. It does not queue.
- `dp_vec_a` always reflects the latched vector, so it is stable through a whole pass even if `in_vec` changes.
- Reset values: `busy`=0, `done`=0, `w_rd_en`=0, `w_addr`=0, `out_valid`=0, `out_idx`=0, `out_data`=0. The `dp_vec_a`/`dp_vec_b` registers are 0.
- Reset asserted mid-pass returns the block to IDLE immediately. No `done` pulse is produced, and any partial result is discarded.

## Timing
- `start` is sampled at edge 0. FETCH occupies cycle 1, WAIT cycle 2, COMPUTE cycle 3.
- The first `out_valid` is visible in cycle 4.
- With `out_ready` held at 1, each neuron takes 4 cycles.
- The `done` pulse falls in cycle 4*OUT_DIM+1, and the block is back in IDLE at cycle 4*OUT_DIM+2.
- Each cycle that `out_ready` is low in WRITE adds one cycle of stall. The weight memory is not read during a stall.
- At most one read is outstanding at any time, so the memory needs no flow control.

## Configuration
- Macro `MLP_CTRL_RELU_EN`.
- **Defined:** after the bias add, a negative result (MSB set) is replaced with 0 before it is registered.
- **Undefined:** the raw wrapped sum is output.
- Latency is identical either way.

## Test plan
Unless a scenario says otherwise, use DATA_W=16, IN_DIM=4, OUT_DIM=3, `in_vec`=[1,2,3,4], and `out_ready`=1.

- **Basic pass:** rows [1,1,1,1]/b0, [-1,0,0,0]/b-5, [2,2,2,2]/b1.
  - Required outputs: (0,10), (1,-6), (2,21).
  - With `MLP_CTRL_RELU_EN` defined, output 1 becomes 0.
  - `done` pulses in cycle 13, and `busy` is high in cycles 1–13.
- **Backpressure:** drive `out_ready` low for 3 cycles in the first WRITE.
  - `out_valid` stays high and `out_data`=10 stays stable.
  - Only one `w_rd_en` pulse per neuron; `done` moves to cycle 16.
- **Start during busy:** pulse `start` with a different `in_vec` in cycles 2 and 7.
  - Results are unchanged from the basic pass, and there is exactly one `done`.
- **Wrap:** DATA_W=8, IN_DIM=1, OUT_DIM=1, in=[100], weight [2], bias 0.
  - `out_data`=-56 without ReLU, or 0 with ReLU.
  - `done` pulses in cycle 5.
- **Reset mid-pass:** assert `rst` during the second WAIT.
  - All outputs are 0 and the state is IDLE that same cycle.
  - No `done` is produced, and a following `start` produces the full correct pass.
